// File: rtl/bit_mask_builder_if.sv
// Purpose : command/result bundle for bit_mask_builder (index commands in, frame mask out).
// Latency : n/a (wires only).
// Backpressure: in_valid/in_ready on the command side, out_valid/out_ready on the result side.
//
// Signals:
//   in_valid/in_ready  command handshake
//   in_index[31:0]     bit index 0..31, 32'hFFFF_FFFF = "no bit"
//   in_op[1:0]         00 SET, 01 CLR, 10 TGL, 11 ONEHOT
//   in_last            final command of the frame
//   mask_out[31:0]     registered working mask
//   out_valid/out_ready result handshake
//   bad_seen, bad_cnt  sticky error flag and saturating error count
interface bit_mask_builder_if #(
    parameter int ERRW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_index;
    logic [1:0]      in_op;
    logic            in_last;
    logic [31:0]     mask_out;
    logic            out_valid;
    logic            out_ready;
    logic            bad_seen;
    logic [ERRW-1:0] bad_cnt;

    // Producer of commands / consumer of results.
    modport master (
        output in_valid, in_index, in_op, in_last, out_ready,
        input  in_ready, mask_out, out_valid, bad_seen, bad_cnt
    );

    // The mask builder itself.
    modport slave (
        input  in_valid, in_index, in_op, in_last, out_ready,
        output in_ready, mask_out, out_valid, bad_seen, bad_cnt
    );
endinterface

// File: rtl/bit_mask_builder.sv
// Purpose : accumulates single-bit SET/CLR/TGL/ONEHOT commands into a 32-bit mask per frame.
// Latency : 1 cycle from accepting edge to mask_out; result held from the cycle after in_last.
// Backpressure: in_ready low while a finished mask waits for out_ready; in_valid ignored then.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (clears mask, state and error counters)
//   bus  bit_mask_builder_if.slave (command, result and error status signals)
module bit_mask_builder #(
    parameter int ERRW = 8
) (
    input  logic                clk,
    input  logic                rst,
    bit_mask_builder_if.slave   bus
);

    localparam logic [1:0] OP_SET    = 2'b00;
    localparam logic [1:0] OP_CLR    = 2'b01;
    localparam logic [1:0] OP_TGL    = 2'b10;
    localparam logic [1:0] OP_ONEHOT = 2'b11;

    localparam logic [31:0] NO_BIT   = 32'hFFFF_FFFF;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       mask_q, mask_d;
    logic              bad_seen_q, bad_seen_d;
    logic [ERRW-1:0]   bad_cnt_q, bad_cnt_d;

    logic              idx_ok;
    logic              idx_none;
    logic [31:0]       bit_sel;

    assign idx_ok   = (bus.in_index < 32'd32);
    assign idx_none = (bus.in_index == NO_BIT);
    assign bit_sel  = 32'h1 << bus.in_index[4:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCUM;
            mask_q     <= '0;
            bad_seen_q <= 1'b0;
            bad_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            bad_seen_q <= bad_seen_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        bad_seen_d = bad_seen_q;
        bad_cnt_d  = bad_cnt_q;

        case (state_q)
            ACCUM: begin
                if (bus.in_valid) begin
                    if (idx_ok) begin
                        case (bus.in_op)
                            OP_SET:    mask_d = mask_q | bit_sel;
                            OP_CLR:    mask_d = mask_q & ~bit_sel;
                            OP_TGL:    mask_d = mask_q ^ bit_sel;
                            OP_ONEHOT: mask_d = bit_sel;
                            default:   mask_d = mask_q;
                        endcase
                    end else if (idx_none) begin
                        // "No bit": only ONEHOT has an effect (loads an empty mask).
                        if (bus.in_op == OP_ONEHOT) begin
                            mask_d = '0;
                        end
                    end else begin
                        bad_seen_d = 1'b1;
                        if (bad_cnt_q != {ERRW{1'b1}}) begin
                            bad_cnt_d = bad_cnt_q + 1'b1;
                        end
                    end
                    // The last command is folded into the mask on the same edge that
                    // freezes it for the consumer.
                    if (bus.in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = ACCUM;
                    mask_d  = '0;
                end
            end
            default: begin
                state_d = ACCUM;
                mask_d  = '0;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.mask_out  = mask_q;
    assign bus.bad_seen  = bad_seen_q;
    assign bus.bad_cnt   = bad_cnt_q;

endmodule
